axi4_lite_read_slave: RTL and testbench



---
 rtl/axi4_lite_read_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi4_lite_read_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_read_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_read_slave
//
// AXI4-Lite read-channel slave in front of a word-addressed memory whose
// synchronous read port has a fixed latency of READ_LATENCY cycles. Accepts one
// AR transaction at a time, decodes the address window and alignment, reads the
// memory for good addresses, and returns an R response. Bad addresses get
// SLVERR with zero data and never touch the memory. A saturating 8-bit counter
// records the number of SLVERR responses issued.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   S_AXI_ARADDR/ARVALID/ARREADY   read address channel
//   S_AXI_RDATA/RRESP/RVALID/RREADY read data channel (RRESP 00 OKAY, 10 SLVERR)
//   mem_rd_en           one-cycle read strobe to the memory
//   mem_rd_addr         word index presented to the memory (held after strobe)
//   mem_rd_data         memory read data, valid READ_LATENCY cycles after strobe
//   err_count           saturating count of SLVERR responses
//
// Every output comes from a register or is decoded from the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module axi4_lite_read_slave #(
  parameter int unsigned              ADDR_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = '0,
  parameter int unsigned              MEM_DEPTH    = 1024,
  parameter int unsigned              READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic [7:0]                   err_count
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  // Top of the window, one bit wider than the address so that a window ending
  // at the very top of the address space does not wrap to zero.
  localparam logic [ADDR_WIDTH:0] WIN_TOP =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t state, next_state;

  logic [2:0]            lat_cnt;
  logic                  err_lat;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            err_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Address decode on the incoming request. The borrow bit of the extended
  // subtraction flags an address below BASE_ADDR.
  logic [ADDR_WIDTH:0] offset_ext;
  logic                addr_err;
  logic [IDX_W-1:0]    word_idx;

  always_comb begin
    offset_ext = {1'b0, S_AXI_ARADDR} - {1'b0, BASE_ADDR};
    addr_err   = offset_ext[ADDR_WIDTH]
              || ({1'b0, S_AXI_ARADDR} >= WIN_TOP)
              || (S_AXI_ARADDR[1:0] != 2'b00);
    word_idx   = IDX_W'(offset_ext[ADDR_WIDTH-1:0] >> 2);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A bad address is parked in MEM_WAIT for a single cycle
  // (counter preloaded with 1, no memory strobe) so the SLVERR response shows
  // up one edge after the AR handshake while the memory is never accessed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (S_AXI_ARVALID) begin
          next_state = addr_err ? MEM_WAIT : MEM_READ;
        end
      end
      MEM_READ: next_state = MEM_WAIT;
      MEM_WAIT: begin
        if (lat_cnt == 3'd1) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (S_AXI_RREADY) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt   <= 3'd0;
      err_lat   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      idx_q     <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (S_AXI_ARVALID) begin
            err_lat <= addr_err;
            if (addr_err) begin
              lat_cnt <= 3'd1;
            end else begin
              idx_q <= word_idx;
            end
          end
        end
        MEM_READ: begin
          lat_cnt <= 3'(READ_LATENCY);
        end
        MEM_WAIT: begin
          if (lat_cnt == 3'd1) begin
            if (err_lat) begin
              rdata_q   <= '0;
              rresp_q   <= RESP_SLVERR;
              err_cnt_q <= sat_inc8(err_cnt_q);
            end else begin
              rdata_q <= mem_rd_data;
              rresp_q <= RESP_OKAY;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          // Return the R channel to its idle values once the beat is taken.
          if (S_AXI_RREADY) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXI_ARREADY = (state == IDLE);
  assign S_AXI_RVALID  = (state == RESP);
  assign mem_rd_en     = (state == MEM_READ);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign mem_rd_addr   = idx_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_read_slave
//
// Two instances of the read slave share one clock and reset: instance 0 uses
// READ_LATENCY=1 and instance 1 uses READ_LATENCY=3, both with BASE_ADDR=0 and
// MEM_DEPTH=1024. Each has its own memory model with the matching read latency.
// -----------------------------------------------------------------------------
module tb_axi4_lite_read_slave;

  localparam int DEPTH = 1024;
  localparam longint BASE = 0;

  logic        clk;
  logic        rst_n;
  logic [31:0] araddr     [2];
  logic        arvalid    [2];
  logic        arready    [2];
  logic [31:0] rdata      [2];
  logic [1:0]  rresp      [2];
  logic        rvalid     [2];
  logic        rready     [2];
  logic        mem_rd_en  [2];
  logic [9:0]  mem_rd_addr[2];
  logic [31:0] mem_rd_data[2];
  logic [7:0]  err_count  [2];

  int checks = 0;
  int errors = 0;
  int exp_ec [2];
  int lat_of [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_read_slave #(.READ_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_ARADDR(araddr[0]), .S_AXI_ARVALID(arvalid[0]), .S_AXI_ARREADY(arready[0]),
    .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]), .S_AXI_RVALID(rvalid[0]),
    .S_AXI_RREADY(rready[0]), .mem_rd_en(mem_rd_en[0]), .mem_rd_addr(mem_rd_addr[0]),
    .mem_rd_data(mem_rd_data[0]), .err_count(err_count[0])
  );

  axi4_lite_read_slave #(.READ_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_ARADDR(araddr[1]), .S_AXI_ARVALID(arvalid[1]), .S_AXI_ARREADY(arready[1]),
    .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]), .S_AXI_RVALID(rvalid[1]),
    .S_AXI_RREADY(rready[1]), .mem_rd_en(mem_rd_en[1]), .mem_rd_addr(mem_rd_addr[1]),
    .mem_rd_data(mem_rd_data[1]), .err_count(err_count[1])
  );

  // Memory contents: word 4 is DEADBEEF, every other word is C0DE_0000 + index.
  function automatic logic [31:0] memw(input int idx);
    return (idx == 4) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(idx);
  endfunction

  // Memory models: data appears READ_LATENCY cycles after the strobe cycle.
  // Cycles without a strobe push noise through the pipe so a capture at the
  // wrong moment returns a wrong word.
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  always @(posedge clk) begin
    pipe0 <= mem_rd_en[0] ? memw(int'(mem_rd_addr[0])) : (32'hBAD0_0000 | $urandom_range(0, 65535));
    pipe1[0] <= mem_rd_en[1] ? memw(int'(mem_rd_addr[1])) : (32'hBAD1_0000 | $urandom_range(0, 65535));
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  assign mem_rd_data[0] = pipe0;
  assign mem_rd_data[1] = pipe1[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: response for an address from the window/alignment rules.
  task automatic ref_model(input logic [31:0] addr, output logic err, output logic [31:0] data);
    longint a;
    a = longint'(addr);
    err = (a < BASE) || (a >= BASE + 4 * DEPTH) || (a % 4 != 0);
    data = err ? 32'h0 : memw(int'((a - BASE) / 4));
  endtask

  // One complete read on instance i. stall = cycles RREADY is held low after
  // RVALID rises; stall_ar drives a new AR request during those stall cycles.
  task automatic do_read(input int i, input logic [31:0] addr, input int stall,
                         input logic stall_ar, input logic [31:0] stall_addr,
                         input logic exp_err, input logic [31:0] exp_data);
    int wait_cyc;
    int lat;
    int en_cnt;
    int exp_lat;
    logic [9:0] en_addr;
    logic busy_ok;
    logic [31:0] held_data;
    logic [1:0] held_resp;
    logic stable_ok;

    exp_lat = exp_err ? 1 : 1 + lat_of[i];
    @(negedge clk);
    araddr[i]  = addr;
    arvalid[i] = 1'b1;
    rready[i]  = (stall == 0);
    wait_cyc = 0;
    while (!arready[i]) begin
      @(negedge clk);
      wait_cyc++;
      if (wait_cyc > 50) begin
        chk("arready_timeout", 32'(arready[i]), 32'h1);
        arvalid[i] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    arvalid[i] = 1'b0;

    lat = 0;
    en_cnt = 0;
    en_addr = '0;
    busy_ok = 1'b1;
    while (!rvalid[i] && lat < 20) begin
      if (mem_rd_en[i]) begin
        en_cnt++;
        en_addr = mem_rd_addr[i];
      end
      if (arready[i]) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rvalid_latency", 32'(lat), 32'(exp_lat));
    chk("mem_rd_en_pulses", 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) chk("mem_rd_addr", 32'(en_addr), 32'((longint'(addr) - BASE) / 4));
    chk("arready_low_while_busy", 32'(busy_ok), 32'h1);
    chk("rdata", rdata[i], exp_data);
    chk("rresp", 32'(rresp[i]), exp_err ? 32'h2 : 32'h0);
    if (exp_err && exp_ec[i] < 255) exp_ec[i]++;
    chk("err_count", 32'(err_count[i]), 32'(exp_ec[i]));

    if (stall > 0) begin
      held_data = rdata[i];
      held_resp = rresp[i];
      stable_ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (stall_ar) begin
          araddr[i]  = stall_addr;
          arvalid[i] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!rvalid[i] || rdata[i] !== held_data || rresp[i] !== held_resp || arready[i])
          stable_ok = 1'b0;
      end
      chk("stall_stable", 32'(stable_ok), 32'h1);
      @(negedge clk);
      rready[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    rready[i] = 1'b0;
    chk("rvalid_after_handshake", 32'(rvalid[i]), 32'h0);
    chk("arready_after_handshake", 32'(arready[i]), 32'h1);
  endtask

  task automatic chk_reset_values(input int i);
    chk("rst_arready", 32'(arready[i]), 32'h1);
    chk("rst_rvalid", 32'(rvalid[i]), 32'h0);
    chk("rst_rdata", rdata[i], 32'h0);
    chk("rst_rresp", 32'(rresp[i]), 32'h0);
    chk("rst_mem_rd_en", 32'(mem_rd_en[i]), 32'h0);
    chk("rst_mem_rd_addr", 32'(mem_rd_addr[i]), 32'h0);
    chk("rst_err_count", 32'(err_count[i]), 32'h0);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] addr;
    int          stall;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic        e;
    logic [31:0] d;
    logic [31:0] a;
    int          inst;
    int          kind;

    vecs[0] = '{0, 32'h0000_0010, 0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{0, 32'h0000_1000, 0, 1'b1, 32'h0000_0000};
    vecs[2] = '{0, 32'h0000_0006, 0, 1'b1, 32'h0000_0000};
    vecs[3] = '{0, 32'h0000_0FFC, 0, 1'b0, 32'hC0DE_03FF};
    vecs[4] = '{0, 32'h0000_0000, 0, 1'b0, 32'hC0DE_0000};
    vecs[5] = '{0, 32'hFFFF_FFFC, 0, 1'b1, 32'h0000_0000};
    vecs[6] = '{0, 32'h0000_0FFF, 1, 1'b1, 32'h0000_0000};
    vecs[7] = '{1, 32'h0000_0FFC, 0, 1'b0, 32'hC0DE_03FF};
    vecs[8] = '{1, 32'h0000_0010, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[9] = '{1, 32'h0000_1004, 0, 1'b1, 32'h0000_0000};

    lat_of[0] = 1;
    lat_of[1] = 3;
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0; exp_ec[i] = 0;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk_reset_values(i);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int v = 0; v < 10; v++)
      do_read(vecs[v].inst, vecs[v].addr, vecs[v].stall, 1'b0, 32'h0, vecs[v].exp_err, vecs[v].exp_data);

    // Backpressure with an AR request raised during the stall, then that
    // request served once the R beat has been taken.
    do_read(0, 32'h0000_0010, 5, 1'b1, 32'h0000_0014, 1'b0, 32'hDEAD_BEEF);
    do_read(0, 32'h0000_0014, 0, 1'b0, 32'h0, 1'b0, 32'hC0DE_0005);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      inst = n % 2;
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        2:    a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        default: a = 32'h0000_1000 + $urandom_range(0, 32'h00FF_FFFF);
      endcase
      ref_model(a, e, d);
      do_read(inst, a, $urandom_range(0, 2), 1'b0, 32'h0, e, d);
    end

    // Misaligned reads until the error counter saturates.
    for (int n = 0; n < 300; n++) begin
      ref_model(32'h0000_0006, e, d);
      do_read(0, 32'h0000_0006, 0, 1'b0, 32'h0, e, d);
    end
    chk("err_count_saturated", 32'(err_count[0]), 32'd255);

    // Reset asserted while instance 1 sits in its memory-wait phase.
    @(negedge clk);
    araddr[1]  = 32'h0000_0020;
    arvalid[1] = 1'b1;
    @(posedge clk);
    #1;
    arvalid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk_reset_values(i);
    exp_ec[0] = 0;
    exp_ec[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("no_stale_rvalid", 32'(rvalid[1]), 32'h0);
    end
    do_read(1, 32'h0000_0000, 0, 1'b0, 32'h0, 1'b0, 32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
